// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with a programmable inclusive upper limit,
// wrap or saturate at the bounds, synchronous load and registered event flags.
module updown_counter_param #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             updown,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_zero,
   output logic             wrap_pulse,
   output logic             sat_pulse,
   output logic             ovf_sticky
);

   logic [WIDTH-1:0] next_count;
   logic             wrap_ev;
   logic             sat_ev;

   assign at_max  = (count >= limit);
   assign at_zero = (count == '0);

   always_comb begin
      next_count = count;
      wrap_ev    = 1'b0;
      sat_ev     = 1'b0;
      if (load) begin
         next_count = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         if (updown) begin
            if (count < limit) begin
               next_count = count + 1'b1;
            end else if (!sat_mode) begin
               next_count = '0;
               wrap_ev    = 1'b1;
            end else begin
               next_count = limit;
               sat_ev     = 1'b1;
            end
         end else begin
            // A count above a freshly lowered limit just walks down, no event.
            if (count != '0) begin
               next_count = count - 1'b1;
            end else if (!sat_mode) begin
               next_count = limit;
               wrap_ev    = 1'b1;
            end else begin
               sat_ev = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         wrap_pulse <= 1'b0;
         sat_pulse  <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         count      <= next_count;
         wrap_pulse <= wrap_ev;
         sat_pulse  <= sat_ev;
         // A new event beats a simultaneous clear.
         if (wrap_ev || sat_ev) begin
            ovf_sticky <= 1'b1;
         end else if (clr_flag) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4) with immediate-assertion
// checks sampled 1 time unit after each rising edge.
module tb_updown_counter_param;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst, en, updown, sat_mode, load, clr_flag;
   logic [W-1:0] limit, load_val;
   logic [W-1:0] count;
   logic         at_max, at_zero, wrap_pulse, sat_pulse, ovf_sticky;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   updown_counter_param #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en), .updown(updown), .sat_mode(sat_mode),
      .limit(limit), .load(load), .load_val(load_val), .clr_flag(clr_flag),
      .count(count), .at_max(at_max), .at_zero(at_zero),
      .wrap_pulse(wrap_pulse), .sat_pulse(sat_pulse), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_load(input int v);
      load = 1'b1; load_val = W'(v);
      step();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; updown = 1'b1; sat_mode = 1'b0; load = 1'b0;
      clr_flag = 1'b0; limit = 4'd15; load_val = '0;
      #2;
      step(); step();
      chk("rst_count", count, 0);
      chk("rst_wrap", wrap_pulse, 0);
      chk("rst_sat", sat_pulse, 0);
      chk("rst_sticky", ovf_sticky, 0);
      chk("rst_at_zero", at_zero, 1);
      chk("rst_at_max", at_max, 0);

      // Up, wrap, full range
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("up_wrap_count", count, i % 16);
         chk("up_wrap_pulse", wrap_pulse, (i == 16) ? 1 : 0);
      end
      chk("up_wrap_sticky", ovf_sticky, 1);

      // Saturate up at limit 9, then down to 0
      limit = 4'd9; sat_mode = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("sat_up_count", count, (i < 9) ? i : 9);
         chk("sat_up_pulse", sat_pulse, (i >= 10) ? 1 : 0);
      end
      chk("sat_at_max", at_max, 1);
      updown = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk("sat_dn_count", count, (i <= 9) ? 9 - i : 0);
         chk("sat_dn_pulse", sat_pulse, (i == 10) ? 1 : 0);
      end

      // Down-wrap to limit, then clamped load
      sat_mode = 1'b0; limit = 4'd5;
      step();
      chk("dn_wrap_count", count, 5);
      chk("dn_wrap_pulse", wrap_pulse, 1);
      en = 1'b0;
      do_load(12);
      chk("load_clamp_count", count, 5);
      chk("load_clamp_wrap", wrap_pulse, 0);
      chk("load_clamp_sat", sat_pulse, 0);

      // Limit lowered below count
      limit = 4'd15; do_load(12);
      chk("load12", count, 12);
      limit = 4'd6; en = 1'b1; updown = 1'b1; sat_mode = 1'b0;
      step();
      chk("lower_wrap_count", count, 0);
      chk("lower_wrap_pulse", wrap_pulse, 1);
      en = 1'b0; limit = 4'd15; do_load(12);
      limit = 4'd6; en = 1'b1; sat_mode = 1'b1;
      step();
      chk("lower_sat_count", count, 6);
      chk("lower_sat_pulse", sat_pulse, 1);
      en = 1'b0; limit = 4'd15; do_load(12);
      limit = 4'd6; en = 1'b1; updown = 1'b0;
      step();
      chk("lower_dn_count", count, 11);
      chk("lower_dn_wrap", wrap_pulse, 0);
      chk("lower_dn_sat", sat_pulse, 0);

      // limit == 0, up wrap every cycle
      limit = 4'd0; sat_mode = 1'b0; updown = 1'b1; en = 1'b0;
      do_load(0);
      en = 1'b1;
      step();
      chk("lim0_count_a", count, 0);
      chk("lim0_wrap_a", wrap_pulse, 1);
      step();
      chk("lim0_count_b", count, 0);
      chk("lim0_wrap_b", wrap_pulse, 1);

      // Load wins over en
      limit = 4'd15; en = 1'b1; updown = 1'b1;
      do_load(3);
      chk("load_en_count", count, 3);
      chk("load_en_wrap", wrap_pulse, 0);

      // Clear, then event and clear together, then clear alone
      en = 1'b0; clr_flag = 1'b1;
      step();
      chk("clr_sticky", ovf_sticky, 0);
      clr_flag = 1'b0;
      do_load(15);
      en = 1'b1; clr_flag = 1'b1;
      step();
      chk("evt_clr_count", count, 0);
      chk("evt_clr_wrap", wrap_pulse, 1);
      chk("evt_clr_sticky", ovf_sticky, 1);
      en = 1'b0;
      step();
      chk("clr_alone_sticky", ovf_sticky, 0);
      clr_flag = 1'b0;

      // Reset mid-count would otherwise saturate
      limit = 4'd7; sat_mode = 1'b1; do_load(7);
      en = 1'b1; updown = 1'b1; rst = 1'b1;
      step();
      chk("midrst_count", count, 0);
      chk("midrst_sat", sat_pulse, 0);
      chk("midrst_sticky", ovf_sticky, 0);
      rst = 1'b0; en = 1'b0;
      do_load(4);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_count", count, 4);
         chk("hold_flags", {wrap_pulse, sat_pulse, ovf_sticky}, 0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
